// File: rtl/fwd_unit.sv
// Operand forwarding and hazard unit for the Y86 decode stage.
// Bypass from E/M/W plus a retired-write shadow, with stall counting.
module fwd_unit #(
    parameter int NSRC      = 2,
    parameter int WIDTH     = 32,
    parameter int MODE      = 1,
    parameter int STALL_MAX = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*NSRC-1:0]     d_src_i,
    input  logic [WIDTH*NSRC-1:0] d_rval_i,
    input  logic [3:0]            E_dstM_i,
    input  logic [3:0]            e_dstE_i,
    input  logic [WIDTH-1:0]      e_valE_i,
    input  logic [3:0]            M_dstM_i,
    input  logic [WIDTH-1:0]      m_valM_i,
    input  logic [3:0]            M_dstE_i,
    input  logic [WIDTH-1:0]      M_valE_i,
    input  logic [3:0]            W_dstM_i,
    input  logic [WIDTH-1:0]      W_valM_i,
    input  logic [3:0]            W_dstE_i,
    input  logic [WIDTH-1:0]      W_valE_i,
    output logic [WIDTH*NSRC-1:0] d_val_o,
    output logic                  stall_o,
    output logic [15:0]           stall_cnt_o,
    output logic                  err_o
);

    localparam logic [3:0]  RNONE   = 4'hF;
    localparam logic [15:0] RUN_MAX = 16'(STALL_MAX);

    logic [3:0]       shm_dst_q, shm_dst_d;
    logic [WIDTH-1:0] shm_val_q, shm_val_d;
    logic [3:0]       she_dst_q, she_dst_d;
    logic [WIDTH-1:0] she_val_q, she_val_d;
    logic [15:0]      stall_cnt_q, stall_cnt_d;
    logic [15:0]      run_q, run_d;
    logic             err_q, err_d;

    function automatic logic hit(input logic [3:0] s, input logic [3:0] d);
        return (s != RNONE) && (d != RNONE) && (s == d);
    endfunction

    always_comb begin
        logic [3:0]       src;
        logic [WIDTH-1:0] rval;
        d_val_o = '0;
        stall_o = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            src  = d_src_i[4*k +: 4];
            rval = d_rval_i[WIDTH*k +: WIDTH];
            if (MODE == 0) begin
                d_val_o[WIDTH*k +: WIDTH] = rval;
                if (hit(src, E_dstM_i) || hit(src, e_dstE_i) ||
                    hit(src, M_dstM_i) || hit(src, M_dstE_i) ||
                    hit(src, W_dstM_i) || hit(src, W_dstE_i) ||
                    hit(src, shm_dst_q) || hit(src, she_dst_q))
                    stall_o = 1'b1;
            end else begin
                // First match wins; youngest producer has priority.
                if (hit(src, e_dstE_i))
                    d_val_o[WIDTH*k +: WIDTH] = e_valE_i;
                else if (hit(src, M_dstM_i))
                    d_val_o[WIDTH*k +: WIDTH] = m_valM_i;
                else if (hit(src, M_dstE_i))
                    d_val_o[WIDTH*k +: WIDTH] = M_valE_i;
                else if (hit(src, W_dstM_i))
                    d_val_o[WIDTH*k +: WIDTH] = W_valM_i;
                else if (hit(src, W_dstE_i))
                    d_val_o[WIDTH*k +: WIDTH] = W_valE_i;
                else if (hit(src, shm_dst_q))
                    d_val_o[WIDTH*k +: WIDTH] = shm_val_q;
                else if (hit(src, she_dst_q))
                    d_val_o[WIDTH*k +: WIDTH] = she_val_q;
                else
                    d_val_o[WIDTH*k +: WIDTH] = rval;
                if (hit(src, E_dstM_i))
                    stall_o = 1'b1;
            end
        end
    end

    always_comb begin
        shm_dst_d   = W_dstM_i;
        shm_val_d   = W_valM_i;
        she_dst_d   = W_dstE_i;
        she_val_d   = W_valE_i;
        stall_cnt_d = stall_cnt_q;
        run_d       = '0;
        if (stall_o) begin
            if (stall_cnt_q != 16'hFFFF)
                stall_cnt_d = stall_cnt_q + 16'd1;
            run_d = (run_q >= RUN_MAX) ? run_q : run_q + 16'd1;
        end
        err_d = err_q | (run_d >= RUN_MAX);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shm_dst_q   <= RNONE;
            shm_val_q   <= '0;
            she_dst_q   <= RNONE;
            she_val_q   <= '0;
            stall_cnt_q <= '0;
            run_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            shm_dst_q   <= shm_dst_d;
            shm_val_q   <= shm_val_d;
            she_dst_q   <= she_dst_d;
            she_val_q   <= she_val_d;
            stall_cnt_q <= stall_cnt_d;
            run_q       <= run_d;
            err_q       <= err_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign err_o       = err_q;

endmodule

// File: doc/fwd_unit.md
# fwd_unit

Parametrised operand-forwarding and hazard unit for the Y86 pipeline decode stage. It replaces the per-operand forwarding muxes with one block that serves `NSRC` source operands. It has two modes:
- **Forward mode:** full bypass from E/M/W, with load-use stall detection.
- **Interlock mode:** no bypass; decode stalls until hazards drain.

It adds a retired-write shadow stage for the registered-read register file, a stall-cycle counter and a stall watchdog.

## Interface
Parameters:
- `NSRC`, 2 — number of decode source operands served.
- `WIDTH`, 32 — data word width.
- `MODE`, 1 — 1 = forward mode (bypass plus load-use stall); 0 = interlock mode (stall on any in-flight match, no bypass).
- `STALL_MAX`, 8 — number of consecutive stall cycles before `err_o` is set.

Ports (`RNONE` = 4'hF):
- `clk`  in  1  — pipeline clock; all state updates on the rising edge.
- `rst`  in  1  — reset; asynchronous, active-low.
- `d_src_i`  in  4*NSRC  — register IDs of the decode sources; operand k uses bits [4k+3:4k].
- `d_rval_i`  in  WIDTH*NSRC  — register-file read data per operand.
- `E_dstM_i`  in  4  — load destination of the instruction in E.
- `e_dstE_i`, `e_valE_i`  in  4, WIDTH — ALU result in E.
- `M_dstM_i`, `m_valM_i`  in  4, WIDTH — memory read result in M.
- `M_dstE_i`, `M_valE_i`  in  4, WIDTH — ALU result in M.
- `W_dstM_i`, `W_valM_i`  in  4, WIDTH — memory result in W.
- `W_dstE_i`, `W_valE_i`  in  4, WIDTH — ALU result in W.
- `d_val_o`  out  WIDTH*NSRC  — forwarded operand values.
- `stall_o`  out  1  — stall F/D and inject a bubble into E this cycle.
- `stall_cnt_o`  out  16  — saturating count of stall cycles.
- `err_o`  out  1  — sticky watchdog error.

## Operation
**Forward mode: per-operand selection**
- Each operand k selects independently, first match wins:
  1. `e_dstE`
  2. `M_dstM`
  3. `M_dstE`
  4. `W_dstM`
  5. `W_dstE`
  6. shadow M entry
  7. shadow E entry
  8. `d_rval_i`
- A source equal to `RNONE` always takes `d_rval_i`.
- A destination equal to `RNONE` never matches.

**Shadow stage**
- The register file has one-cycle registered read, so writes retired in the previous cycle are not yet visible.
- On each clock, the shadow stage captures (`W_dstM`, `W_valM`) and (`W_dstE`, `W_valE`) into two entries.
- While `stall_o`=1, the shadow still updates.

**Load-use hazard (forward mode)**
- `stall_o` = 1 when `E_dstM_i` != `RNONE` and it equals any `d_src` that is not `RNONE`.
- This is a combinational, single-cycle stall; on the following cycle the load is in M and `m_valM` forwards it.

**Interlock mode (`MODE`=0)**
- `d_val_o` = `d_rval_i` always.
- `stall_o` = 1 while any non-`RNONE` source matches any of `E_dstM`, `e_dstE`, `M_dstM`, `M_dstE`, `W_dstM`, `W_dstE`, or either shadow destination.

**Counters**
- `stall_cnt_o` increments on every clock with `stall_o`=1 and saturates at 16'hFFFF.
- The run-length counter counts consecutive stall cycles and clears on any cycle with `stall_o`=0.
- When the run-length counter reaches `STALL_MAX`, `err_o` is set and stays set until reset.

**Reset**
- Shadow destinations = `RNONE`, shadow values = 0.
- `stall_cnt_o` = 0, run-length counter = 0, `err_o` = 0.

## Timing
- `d_val_o` and `stall_o` are combinational from the inputs and the shadow registers, with zero latency.
- Shadow registers, counters and `err_o` update on the rising `clk` edge.
- Asserting `rst` (low) mid-stall clears all state immediately, with no clock required. Because the shadow destinations become `RNONE`, they cannot forward stale data.
- Simultaneous matches are resolved by the priority order only; there is never a blend of values.
- The same register in both `W_dstM` and `W_dstE` gives the `W_dstM` value, both directly and through the shadow.
- `err_o` is set on the clock edge on which the run-length counter reaches `STALL_MAX`. With `STALL_MAX`=8 this is the 8th consecutive stall edge.

## Test plan
- **E-stage bypass:** `d_src`={2,3}, `e_dstE`=2 with `e_valE`=0x11, `M_dstE`=3 with `M_valE`=0x22, `d_rval`=0 → `d_val_o`={0x11,0x22}, `stall_o`=0.
- **Priority and RNONE:** `d_src`={5,F}; `e_dstE`=`M_dstM`=`W_dstE`=5 with values 0xA/0xB/0xC; all destinations for F set → operand0 = 0xA, operand1 = `d_rval` unchanged.
- **Shadow:** cycle n has `W_dstE`=4, `W_valE`=0x77; cycle n+1 has no pipeline match for `d_src`=4 and `d_rval`=0x00 → `d_val_o` = 0x77. Same stimulus after a `rst` pulse → 0x00.
- **Load-use:** `E_dstM`=6, `d_src`={6,F} → `stall_o`=1 for exactly one cycle and `stall_cnt_o` increments by 1. The next cycle has `M_dstM`=6, `m_valM`=0x99 → `d_val_o`[0] = 0x99, `stall_o`=0.
- **Interlock mode (`MODE`=0):** `M_dstE`=1, `d_src`={1,F} → `stall_o`=1 and `d_val_o` = `d_rval`. The hazard drains through W and then the shadow, after which `stall_o`=0 with 3 stall cycles counted.
- **Watchdog and saturation:** `E_dstM` held equal to `d_src` for 8 cycles → `err_o` rises on the 8th edge and stays set after the hazard clears. Forcing `stall_cnt` = 0xFFFE then stalling 3 cycles → `stall_cnt_o` = 0xFFFF.
